// File: rtl/multi_edge_detector_pkg.sv
// edge_pkg: mode encodings and parameter limits for multi_edge_detector.
package edge_pkg;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;
  localparam int MAX_CH    = 32;
  localparam int MAX_SYNC  = 3;
  localparam int MAX_CNT_W = 16;
endpackage

// File: rtl/multi_edge_detector_if.sv
// multi_edge_detector_if: channel inputs, controls and event outputs of multi_edge_detector.
interface multi_edge_detector_if #(parameter int N_CH = 4, parameter int CNT_W = 8);
  logic [N_CH-1:0] in;
  logic enable;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0] irq_mask;
  logic [N_CH-1:0] sticky_clr;
  logic [N_CH-1:0] cnt_clr;
  logic [N_CH-1:0] p_edge;
  logic [N_CH-1:0] n_edge;
  logic [N_CH-1:0] any_edge;
  logic [N_CH-1:0] evt;
  logic [N_CH-1:0] sticky;
  logic [N_CH*CNT_W-1:0] cnt;
  logic irq;
  modport master(output in, enable, mode, irq_mask, sticky_clr, cnt_clr,
                 input p_edge, n_edge, any_edge, evt, sticky, cnt, irq);
  modport slave(input in, enable, mode, irq_mask, sticky_clr, cnt_clr,
                output p_edge, n_edge, any_edge, evt, sticky, cnt, irq);
endinterface

// File: rtl/multi_edge_detector_channel.sv
// edge_channel: one channel's synchroniser, history, edge terms, event gating, sticky flag and counter.
module edge_channel import edge_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8,
  parameter int REG_OUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic enable,
  input  logic [1:0] mode,
  input  logic sticky_clr,
  input  logic cnt_clr,
  output logic p_edge,
  output logic n_edge,
  output logic any_edge,
  output logic evt,
  output logic sticky,
  output logic [CNT_W-1:0] cnt
);
  logic s, h, pe, ne;
  generate
    if (SYNC_STAGES == 0) begin : g_raw
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] q;
      logic [SYNC_STAGES:0] nxt;
      assign nxt = {q, din};
      always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else q <= nxt[SYNC_STAGES-1:0];
      assign s = q[SYNC_STAGES-1];
    end
    if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or posedge reset)
        if (reset) {pe, ne} <= 2'b00;
        else {pe, ne} <= {s & ~h, ~s & h};
    end else begin : g_comb
      assign pe = s & ~h;
      assign ne = ~s & h;
    end
  endgenerate
  always_ff @(posedge clk or posedge reset)
    if (reset) h <= 1'b0;
    else h <= s;
  // combinational edges must also read 0 while reset is held
  assign p_edge = pe & ~reset;
  assign n_edge = ne & ~reset;
  assign any_edge = p_edge | n_edge;
  assign evt = enable & (((|(mode & MODE_RISE)) & p_edge) | ((|(mode & MODE_FALL)) & n_edge));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sticky <= 1'b0;
      cnt <= '0;
    end else begin
      sticky <= evt | (sticky & ~sticky_clr);
      cnt <= cnt_clr ? CNT_W'(evt) : cnt + CNT_W'(evt && !(&cnt));
    end
endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N_CH edge-detect channels with sticky flags, counters and a masked irq.
module multi_edge_detector import edge_pkg::*; #(
  parameter int N_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8,
  parameter int REG_OUT = 0
) (
  input logic clk,
  input logic reset,
  multi_edge_detector_if.slave bus
);
  logic [N_CH-1:0] p_edge, n_edge, any_edge, evt, sticky;
  logic [N_CH*CNT_W-1:0] cnt;
  logic irq;
  generate
    if (N_CH < 1 || N_CH > MAX_CH || SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC ||
        CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_param
      $error("multi_edge_detector: parameter out of range");
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_channel #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .REG_OUT(REG_OUT)) u_ch (
        .clk(clk),
        .reset(reset),
        .din(bus.in[i]),
        .enable(bus.enable),
        .mode(bus.mode[2*i +: 2]),
        .sticky_clr(bus.sticky_clr[i]),
        .cnt_clr(bus.cnt_clr[i]),
        .p_edge(p_edge[i]),
        .n_edge(n_edge[i]),
        .any_edge(any_edge[i]),
        .evt(evt[i]),
        .sticky(sticky[i]),
        .cnt(cnt[i*CNT_W +: CNT_W])
      );
    end
  endgenerate
  always_ff @(posedge clk or posedge reset)
    if (reset) irq <= 1'b0;
    else irq <= |(sticky & bus.irq_mask);
  assign bus.p_edge = p_edge;
  assign bus.n_edge = n_edge;
  assign bus.any_edge = any_edge;
  assign bus.evt = evt;
  assign bus.sticky = sticky;
  assign bus.cnt = cnt;
  assign bus.irq = irq;
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: three configurations (sync 2 / sync 0 comb / sync 0 registered) driven alike
// and checked every cycle against a history-based reference model plus directed constants.
module tb_multi_edge_detector;
  localparam int NC = 1024;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  multi_edge_detector_if #(.N_CH(4), .CNT_W(4)) ifa ();
  multi_edge_detector_if #(.N_CH(4), .CNT_W(4)) ifb ();
  multi_edge_detector_if #(.N_CH(4), .CNT_W(4)) ifc ();
  multi_edge_detector #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(4), .REG_OUT(0)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  multi_edge_detector #(.N_CH(4), .SYNC_STAGES(0), .CNT_W(4), .REG_OUT(0)) dut_b (.clk(clk), .reset(rst), .bus(ifb));
  multi_edge_detector #(.N_CH(4), .SYNC_STAGES(0), .CNT_W(4), .REG_OUT(1)) dut_c (.clk(clk), .reset(rst), .bus(ifc));

  logic [3:0] d_in, d_mk, d_sc, d_cc, n_in, n_mk, n_sc, n_cc;
  logic [7:0] d_md, n_md;
  logic d_en, n_en, n_rst;
  assign ifa.in = d_in; assign ifb.in = d_in; assign ifc.in = d_in;
  assign ifa.enable = d_en; assign ifb.enable = d_en; assign ifc.enable = d_en;
  assign ifa.mode = d_md; assign ifb.mode = d_md; assign ifc.mode = d_md;
  assign ifa.irq_mask = d_mk; assign ifb.irq_mask = d_mk; assign ifc.irq_mask = d_mk;
  assign ifa.sticky_clr = d_sc; assign ifb.sticky_clr = d_sc; assign ifc.sticky_clr = d_sc;
  assign ifa.cnt_clr = d_cc; assign ifb.cnt_clr = d_cc; assign ifc.cnt_clr = d_cc;

  logic [3:0] op[3], on[3], oa[3], oe[3], os[3];
  logic [15:0] oc[3];
  logic oi[3];
  assign op[0] = ifa.p_edge; assign op[1] = ifb.p_edge; assign op[2] = ifc.p_edge;
  assign on[0] = ifa.n_edge; assign on[1] = ifb.n_edge; assign on[2] = ifc.n_edge;
  assign oa[0] = ifa.any_edge; assign oa[1] = ifb.any_edge; assign oa[2] = ifc.any_edge;
  assign oe[0] = ifa.evt; assign oe[1] = ifb.evt; assign oe[2] = ifc.evt;
  assign os[0] = ifa.sticky; assign os[1] = ifb.sticky; assign os[2] = ifc.sticky;
  assign oc[0] = ifa.cnt; assign oc[1] = ifb.cnt; assign oc[2] = ifc.cnt;
  assign oi[0] = ifa.irq; assign oi[1] = ifb.irq; assign oi[2] = ifc.irq;

  // per-cycle record of everything applied to the duts
  logic [3:0] v[NC], mk[NC], sc[NC], cc[NC];
  logic [7:0] md[NC];
  logic rsa[NC], en[NC];
  int c;
  logic [3:0] stk[3];
  int mc[3][4];
  logic mirq[3];
  int cmp = 0, mism = 0;

  function automatic int ss(int d); return d == 0 ? 2 : 0; endfunction
  function automatic bit ro(int d); return d == 2; endfunction
  // a flop holds a captured value in cycle k only if reset was low at edge k and during k
  function automatic bit okc(int k); return k >= 1 && !rsa[k] && !rsa[k-1]; endfunction
  function automatic logic [3:0] sv(int d, int k);
    if (k < 0) return 4'h0;
    if (ss(d) == 0) return v[k];
    for (int j = 0; j < ss(d); j++) if (!okc(k - j)) return 4'h0;
    return v[k - ss(d)];
  endfunction
  function automatic logic [7:0] rawe(int d, int k);
    logic [3:0] s, h;
    if (k < 0 || rsa[k]) return 8'h00;
    s = sv(d, k);
    h = okc(k) ? sv(d, k - 1) : 4'h0;
    return {~s & h, s & ~h};
  endfunction
  function automatic logic [7:0] oute(int d, int k);
    if (!ro(d)) return rawe(d, k);
    return okc(k) ? rawe(d, k - 1) : 8'h00;
  endfunction
  function automatic logic [3:0] evm(int d, int k);
    logic [7:0] e;
    logic [3:0] r;
    r = 4'h0;
    if (k < 0 || rsa[k]) return r;
    e = oute(d, k);
    for (int ch = 0; ch < 4; ch++)
      r[ch] = en[k] & ((md[k][2*ch] & e[ch]) | (md[k][2*ch+1] & e[4+ch]));
    return r;
  endfunction
  function automatic logic [15:0] pack_cnt(int d);
    logic [15:0] r;
    for (int ch = 0; ch < 4; ch++) r[4*ch +: 4] = mc[d][ch][3:0];
    return r;
  endfunction

  task automatic upd();
    logic [3:0] ev;
    for (int d = 0; d < 3; d++) begin
      if (!okc(c)) begin
        stk[d] = 4'h0; mirq[d] = 1'b0;
        for (int ch = 0; ch < 4; ch++) mc[d][ch] = 0;
      end else begin
        ev = evm(d, c - 1);
        mirq[d] = |(stk[d] & mk[c-1]);
        stk[d] = ev | (stk[d] & ~sc[c-1]);
        for (int ch = 0; ch < 4; ch++)
          mc[d][ch] = cc[c-1][ch] ? int'(ev[ch]) : (mc[d][ch] + int'(ev[ch]) > 15 ? 15 : mc[d][ch] + int'(ev[ch]));
      end
    end
  endtask

  task automatic chk(string tag, int d, logic [15:0] obs, logic [15:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, c, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] e;
    for (int d = 0; d < 3; d++) begin
      e = oute(d, c);
      chk("p_edge", d, 16'(op[d]), 16'(e[3:0]));
      chk("n_edge", d, 16'(on[d]), 16'(e[7:4]));
      chk("any_edge", d, 16'(oa[d]), 16'(e[3:0] | e[7:4]));
      chk("event", d, 16'(oe[d]), 16'(evm(d, c)));
      chk("sticky", d, 16'(os[d]), 16'(stk[d]));
      chk("cnt", d, oc[d], pack_cnt(d));
      chk("irq", d, 16'(oi[d]), 16'(mirq[d]));
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (c >= NC - 2) begin
        $display("FAIL cycle_budget: observed %0d cycles, limit %0d", c, NC - 2);
        $fatal(1, "cycle budget exhausted");
      end
      c++;
      d_in = n_in; d_en = n_en; d_md = n_md; d_mk = n_mk; d_sc = n_sc; d_cc = n_cc; rst = n_rst;
      v[c] = n_in; en[c] = n_en; md[c] = n_md; mk[c] = n_mk; sc[c] = n_sc; cc[c] = n_cc; rsa[c] = n_rst;
      upd();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    c = 0;
    n_rst = 1'b1; n_in = 4'b0001; n_en = 1'b1; n_md = 8'h55; n_mk = 4'b0001; n_sc = 4'h0; n_cc = 4'h0;
    rst = n_rst; d_in = n_in; d_en = n_en; d_md = n_md; d_mk = n_mk; d_sc = n_sc; d_cc = n_cc;
    v[0] = n_in; en[0] = n_en; md[0] = n_md; mk[0] = n_mk; sc[0] = n_sc; cc[0] = n_cc; rsa[0] = 1'b1;
    upd();
    run(3);
    // input high through reset release gives exactly one rise event
    n_rst = 1'b0;
    run(6);
    for (int d = 0; d < 3; d++) begin
      chk("rel_cnt", d, oc[d], 16'h0001);
      chk("rel_sticky", d, 16'(os[d]), 16'h0001);
      chk("rel_irq", d, 16'(oi[d]), 16'h0001);
    end
    // channel 1 in fall mode: only the falling edge counts
    n_md = 8'h59;
    n_in = 4'b0011; run(5);
    n_in = 4'b0001; run(8);
    for (int d = 0; d < 3; d++) begin
      chk("fall_cnt", d, oc[d], 16'h0011);
      chk("fall_sticky", d, 16'(os[d]), 16'h0003);
    end
    // channel 2 any-edge saturation, then clear coinciding with an event
    n_md = 8'h79;
    for (int i = 0; i < 20; i++) begin n_in ^= 4'b0100; run(1); end
    run(4);
    for (int d = 0; d < 3; d++) chk("sat_cnt", d, oc[d], 16'h0F11);
    for (int i = 0; i < 6; i++) begin
      n_in ^= 4'b0100;
      n_cc = (i == 5) ? 4'b0100 : 4'b0000;
      run(1);
    end
    n_cc = 4'h0;
    run(1);
    for (int d = 0; d < 3; d++) chk("clr_evt_cnt2", d, 16'(oc[d][11:8]), 16'h0001);
    run(4);
    // sticky clear coinciding with an event on channel 3 (dut b sees it same cycle)
    n_mk = 4'b1000;
    run(2);
    n_in[3] = 1'b1; n_sc = 4'b1000; run(1);
    run(1);
    chk("stk_set_wins", 1, 16'(os[1][3]), 16'h0001);
    n_sc = 4'b0000; run(1);
    chk("stk_clr", 1, 16'(os[1][3]), 16'h0000);
    chk("irq_hold", 1, 16'(oi[1]), 16'h0001);
    run(1);
    chk("irq_drop", 1, 16'(oi[1]), 16'h0000);
    run(4);
    // rising edge while disabled: raw pulse, no event, counter untouched
    n_in[0] = 1'b0; run(5);
    n_en = 1'b0; n_in[0] = 1'b1; run(3);
    chk("dis_p_edge", 0, 16'(op[0][0]), 16'h0001);
    chk("dis_event", 0, 16'(oe[0]), 16'h0000);
    run(1);
    n_en = 1'b1; run(4);
    chk("dis_cnt0", 0, 16'(oc[0][3:0]), 16'h0001);
    // combinational vs registered edge timing, then reset during a pulse
    n_in[1] = 1'b1; run(1);
    chk("comb_same_cycle", 1, 16'(op[1]), 16'h0002);
    chk("reg_not_yet", 2, 16'(op[2]), 16'h0000);
    run(1);
    chk("comb_done", 1, 16'(op[1]), 16'h0000);
    chk("reg_next_cycle", 2, 16'(op[2]), 16'h0002);
    n_in[1] = 1'b0; n_rst = 1'b1; run(1);
    for (int d = 0; d < 3; d++) begin
      chk("rst_n_edge", d, 16'(on[d]), 16'h0000);
      chk("rst_event", d, 16'(oe[d]), 16'h0000);
      chk("rst_cnt", d, oc[d], 16'h0000);
      chk("rst_sticky", d, 16'(os[d]), 16'h0000);
    end
    n_rst = 1'b0; run(3);
    // randomized phase
    for (int i = 0; i < 500; i++) begin
      n_in = 4'($urandom);
      n_en = ($urandom_range(0, 3) != 0);
      n_md = 8'($urandom);
      n_mk = 4'($urandom);
      n_sc = 4'($urandom) & 4'($urandom) & 4'($urandom);
      n_cc = 4'($urandom) & 4'($urandom) & 4'($urandom);
      n_rst = ($urandom_range(0, 39) == 0);
      run(1);
    end
    n_rst = 1'b0;
    run(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel successor to the single-bit edge detector. Each of `N_CH` asynchronous inputs passes through an optional synchroniser. Rising, falling and any-edge pulses are then detected per channel. A per-channel mode selects which edges count as events, and each channel keeps a sticky flag and a saturating event counter. The block sits between raw pins (or debouncer outputs) and control logic that needs edge events, interrupt flags or activity counts.

## Interface
Parameters:
- `N_CH`, 4: number of channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (0..3). 0 = bypass, input used raw.
- `CNT_W`, 8: event counter width per channel (1..16).
- `REG_OUT`, 0: 0 = edge outputs combinational from synced value vs history; 1 = edge outputs registered (+1 cycle).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in`  in  N_CH  raw channel inputs.
- `enable`  in  1  global event enable.
- `mode`  in  2*N_CH  per-channel event select, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 any.
- `irq_mask`  in  N_CH  per-channel interrupt enable.
- `sticky_clr`  in  N_CH  per-channel clear pulse for sticky flag.
- `cnt_clr`  in  N_CH  per-channel clear pulse for counter.
- `p_edge`, `n_edge`, `any_edge`  out  N_CH each  raw edge pulses, unaffected by mode/enable.
- `event`  out  N_CH  mode-filtered, enable-gated edge pulse.
- `sticky`  out  N_CH  latched event flags.
- `cnt`  out  N_CH*CNT_W  per-channel counters, channel i at [(i+1)*CNT_W-1 : i*CNT_W].
- `irq`  out  1  OR over (sticky & irq_mask), registered.

## Operation
- Per-channel datapath:
  - sync chain (`SYNC_STAGES` flops) → `s`;
  - history flop `h <= s` every cycle, regardless of `enable`.
- Edge terms:
  - `p_edge = s & ~h`
  - `n_edge = ~s & h`
  - `any_edge = p_edge | n_edge`
  - When `REG_OUT=1` these pass through one more flop.
- `event = enable & ((mode[0] & p_edge) | (mode[1] & n_edge))`, using the same-timing edge terms.
- Sticky flag:
  - set on `event`;
  - cleared on `sticky_clr`;
  - set wins over clear in the same cycle.
- Counter:
  - increments on `event` and saturates at all-ones.
  - `cnt_clr` alone → 0.
  - `cnt_clr` together with `event` → 1, so no event is lost.
- `irq` register: `irq <= |(sticky & irq_mask)`, using the current `sticky` value.
- Changing `mode` or `enable` never creates an event by itself. Only `s` vs `h` transitions do.

## Timing
- Reset: all sync flops, `h`, output regs, `sticky`, `cnt` and `irq` are 0. All outputs are 0 while reset is asserted.
- Because `h` resets to 0, an input held high through reset release produces exactly one `p_edge` once it reaches `s`. This matches the legacy detector, whose reset state is the low state.
- Latency from the input changing (set up before clk edge 0) to the edge pulse:
  - `SYNC_STAGES` cycles, pulse high in the cycle after edge `SYNC_STAGES-1`;
  - +1 cycle when `REG_OUT=1`;
  - with `SYNC_STAGES=0, REG_OUT=0` the pulse is combinational, in the same cycle.
- Every edge pulse is exactly 1 cycle wide per transition of `s`.
- An input toggling every cycle yields a pulse every cycle.
- `sticky` and `cnt` update at the clock edge ending the `event` cycle; `irq` follows one cycle later.
- Reset asserted mid-pulse clears everything immediately. No event is recorded for that pulse.

## Structure
- Package `edge_pkg` holds:
  - mode localparams `MODE_OFF=2'b00`, `MODE_RISE=2'b01`, `MODE_FALL=2'b10`, `MODE_ANY=2'b11`;
  - parameter range limits.
- Sub-module `edge_channel`, generated `N_CH` times, contains one channel's sync chain, history, edge terms, optional output reg, event gating, sticky and counter.
- Top level keeps only the generate loop, bus slicing and the `irq` reduction register.

## Test plan
- Reset release with `in=4'b0001`, mode all `MODE_RISE`, `SYNC_STAGES=2` → channel 0 `p_edge`/`event` high for 1 cycle, 2 cycles after release; `cnt[0]=1`; `sticky=4'b0001`; `irq` high next cycle if `irq_mask[0]`.
- Channel 1 `MODE_FALL`: drive 0→1→0, each level held 5 cycles → `p_edge[1]` and `n_edge[1]` each pulse once; `event[1]` pulses once, on the fall only; `cnt[1]=1`.
- Channel 2 `MODE_ANY`, `CNT_W=4`: 20 toggles → `cnt[2]` saturates at 15 and stays there. Then `cnt_clr[2]` in the same cycle as an event → `cnt[2]=1`.
- `sticky_clr[3]` asserted in the same cycle as `event[3]` → `sticky[3]` stays 1. `sticky_clr[3]` alone next cycle → 0, and `irq` drops one cycle later.
- `enable=0` during a rising edge on channel 0, then `enable=1` with the input held high → no event and `cnt` unchanged. Raw `p_edge` still pulses.
- `SYNC_STAGES=0`, `REG_OUT=0` vs `REG_OUT=1`: a rising input gives `p_edge` in the same cycle vs one cycle later. Asserting `reset` during the pulse forces all outputs to 0 immediately.
